dma_page_arbiter: RTL
=====================

# dma_page_arbiter

Sits between the 6502 core and the single synchronous memory port, and owns that port. Passes core requests through until the core writes the DMA trigger register. It then stalls the core and copies one 256-byte page from `{page, 8'h00..8'hFF}` to a fixed destination window. When the copy finishes, it returns the port to the core.

## Interface

Parameters:

- `DMA_REG`, `16'h4014`: CPU write address that triggers a page copy. The written byte is the source page.
- `DST_BASE`, `16'h0300`: destination address of byte 0. Byte i goes to `DST_BASE + i`, with 16-bit wrap.

Ports (clock and reset first):

- `clk` in 1: single clock, rising edge.
- `resetn` in 1: reset, asynchronous and active-low.
- `cpu_address` in 16: core request address.
- `cpu_wr_en` in 1: core request is a write.
- `cpu_wr_data` in 8: core write data.
- `cpu_rd_data` out 8: read data to the core. Passthrough of `mem_rd_data`.
- `cpu_rdy` out 1: core request accepted this cycle. When low, the core holds its request.
- `cpu_rd_valid` out 1: `cpu_rd_data` holds the response to the core read accepted last cycle.
- `mem_address` out 16: memory port address.
- `mem_wr_en` out 1: memory port write strobe.
- `mem_wr_data` out 8: memory port write data.
- `mem_rd_data` in 8: memory read data, valid the cycle after the address is presented.
- `dma_busy` out 1: a copy is in progress.
- `dma_done` out 1: one-cycle pulse after the last destination write.

## Operation

State register, one-hot: IDLE, READ, WRITE. The block also holds `page[7:0]` and `idx[7:0]`. Outputs are combinational from the registered state.

IDLE:
- `mem_address` = `cpu_address`, `mem_wr_data` = `cpu_wr_data`, `cpu_rdy` = 1.
- `mem_wr_en` = `cpu_wr_en`, except for a trigger write.
- Trigger condition: `cpu_wr_en` = 1 and `cpu_address` == `DMA_REG`.
- On a trigger, the write is intercepted: `mem_wr_en` = 0 that cycle, `page` <= `cpu_wr_data`, `idx` <= 0, next state is READ.
- A trigger is accepted (`cpu_rdy` = 1 that cycle); the core advances and sees stalls starting the next cycle.

READ:
- `mem_address` = `{page, idx}`, `mem_wr_en` = 0, `cpu_rdy` = 0.
- Next state is WRITE.

WRITE:
- `mem_address` = `DST_BASE + {8'h00, idx}`, truncated to 16 bits (wraps past 16'hFFFF).
- `mem_wr_en` = 1, `mem_wr_data` = `mem_rd_data` (the response to the preceding READ), `cpu_rdy` = 0.
- If `idx` == 8'hFF: next state is IDLE and `dma_done` pulses in the following cycle.
- Otherwise: `idx` <= `idx` + 1, next state is READ.

Flag outputs:
- `dma_busy` = 1 in READ and WRITE.
- `cpu_rd_valid` = registered value of (IDLE && `cpu_rdy` && !`cpu_wr_en`).
- `cpu_rd_data` is always `mem_rd_data`. The core must qualify it with `cpu_rd_valid`.

Boundary conditions:
- Source equal to destination, or overlapping windows: the copy proceeds byte-serially in ascending `idx`. No hazard protection.
- `DMA_REG` reads are not intercepted and pass through to memory.
- Reset mid-copy: state returns to IDLE immediately and asynchronously. The copy is abandoned with a partial destination, and `dma_done` is not pulsed.

## Timing

- Reset values: state IDLE, `page` = 0, `idx` = 0, `cpu_rdy` = 1, `cpu_rd_valid` = 0, `dma_busy` = 0, `dma_done` = 0. `mem_wr_en` follows `cpu_wr_en` (0 with the core in reset).
- Trigger at cycle T. READ runs at T+1, T+3, …, T+511; WRITE runs at T+2, …, T+512.
- `cpu_rdy` is low for cycles T+1 to T+512, i.e. exactly 512 stall cycles.
- `dma_done` is high at T+513, and `cpu_rdy` = 1 again at T+513.
- `mem_rd_data` to `mem_wr_data` is a combinational path; the memory must meet same-cycle read-to-write timing.

## Test plan

- Passthrough: core read at 16'h1234 (memory holds 8'hA5) gives `mem_address` = 16'h1234 the same cycle. Next cycle: `cpu_rd_valid` = 1, `cpu_rd_data` = 8'hA5.
- Basic copy: memory 16'h0200+i = i^8'h5A, core writes 8'h02 to 16'h4014. Requires 16'h4014 not written, `cpu_rdy` low for exactly 512 cycles, 16'h0300+i = i^8'h5A for all i, and one `dma_done` pulse at T+513.
- Destination wrap: `DST_BASE` = 16'hFF80, page 8'h10. Byte 8'h80 lands at 16'h0000 and byte 8'hFF at 16'h007F.
- Register read: core read at 16'h4014 starts no copy; `dma_busy` stays 0 and the read passes through.
- Reset mid-copy: `resetn` low at `idx` = 8'h40 gives IDLE, `cpu_rdy` = 1, `dma_busy` = 0 and no `dma_done`. Destinations 0..8'h3F are written; 8'h41 and above are unchanged.
- Back-to-back: a second trigger on the first cycle after `dma_done` starts a new copy. The intervening core write is intercepted and no memory write occurs.

Source files
------------

// File: rtl/dma_page_arbiter.sv
// Memory-port owner between the 6502 core and one synchronous memory.
// Passes core traffic through until a trigger write, then stalls the core and copies one page.
module dma_page_arbiter #(
  parameter logic [15:0] DMA_REG  = 16'h4014,
  parameter logic [15:0] DST_BASE = 16'h0300
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] cpu_address,
  input  logic        cpu_wr_en,
  input  logic [7:0]  cpu_wr_data,
  output logic [7:0]  cpu_rd_data,
  output logic        cpu_rdy,
  output logic        cpu_rd_valid,
  output logic [15:0] mem_address,
  output logic        mem_wr_en,
  output logic [7:0]  mem_wr_data,
  input  logic [7:0]  mem_rd_data,
  output logic        dma_busy,
  output logic        dma_done
);

  // Core handshake: a request is accepted on any cycle with cpu_rdy high; while cpu_rdy is low the
  // core holds its request unchanged. A read accepted in cycle N is answered in N+1, flagged by
  // cpu_rd_valid with the data on cpu_rd_data.
  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_READ  = 3'b010,
    S_WRITE = 3'b100
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  page, idx;
  logic        done_q, rd_valid_q;
  logic        trigger, last_write;
  logic [15:0] dst_address;

  assign trigger     = (state == S_IDLE) && cpu_wr_en && (cpu_address == DMA_REG);
  assign last_write  = (state == S_WRITE) && (idx == 8'hFF);
  assign dst_address = DST_BASE + {8'h00, idx};

  // State register plus the page/index datapath.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      page       <= 8'h00;
      idx        <= 8'h00;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      done_q     <= last_write;
      rd_valid_q <= (state == S_IDLE) && !cpu_wr_en;
      if (trigger) begin
        page <= cpu_wr_data;
        idx  <= 8'h00;
      end else if ((state == S_WRITE) && !last_write) begin
        idx <= idx + 8'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (trigger) state_nxt = S_READ;
      S_READ:  state_nxt = S_WRITE;
      S_WRITE: state_nxt = last_write ? S_IDLE : S_READ;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The WRITE beat forwards the byte fetched by the preceding READ straight from the memory.
  always_comb begin
    mem_address = cpu_address;
    mem_wr_en   = 1'b0;
    mem_wr_data = cpu_wr_data;
    cpu_rdy     = 1'b0;
    dma_busy    = 1'b0;
    unique case (state)
      S_IDLE: begin
        mem_wr_en = cpu_wr_en && !trigger;
        cpu_rdy   = 1'b1;
      end
      S_READ: begin
        mem_address = {page, idx};
        dma_busy    = 1'b1;
      end
      S_WRITE: begin
        mem_address = dst_address;
        mem_wr_en   = 1'b1;
        mem_wr_data = mem_rd_data;
        dma_busy    = 1'b1;
      end
      default: begin
        cpu_rdy = 1'b1;
      end
    endcase
  end

  assign cpu_rd_data  = mem_rd_data;
  assign cpu_rd_valid = rd_valid_q;
  assign dma_done     = done_q;

endmodule
